// File: rtl/ps2_host_ctrl.sv
// PS/2 host-to-device command controller: inhibit, request-to-send, bit shifting, line-ACK and 0xFA/0xFE response wait.
// Optional resend on 0xFE response is enabled by defining PS2_RESEND_EN.
module ps2_host_ctrl #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drv,
    output logic       ps2_data_drv,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_hold,
    output logic       busy,
    output logic       resp_ok,
    output logic       resp_err,
    output logic [1:0] err_code,
    output logic [2:0] dbg_state
);

`ifdef PS2_RESEND_EN
    localparam bit RESEND_EN = 1'b1;
`else
    localparam bit RESEND_EN = 1'b0;
`endif

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NO_ACK  = 2'b10;
    localparam logic [1:0] ERR_NAK     = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        LACK      = 3'd4,
        WAIT_RESP = 3'd5
    } state_t;

    state_t             state;
    logic [1:0]         clk_s;
    logic [1:0]         dat_s;
    logic [7:0]         cmd_q;
    logic               parity_q;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         bit_idx;
    logic               armed;
    logic [RETRY_W-1:0] retry_cnt;

    logic       fe_raw;
    logic       fe_armed;
    logic       tmo_hit;
    logic       rx_ack;
    logic       rx_nak;
    logic       resend_ok;
    logic       fail;
    logic [1:0] fail_code;

    // Command handshake: a byte is taken on any cycle where cmd_valid and cmd_ready
    // are both high; cmd_ready is high only in IDLE, so nothing is queued while busy.
    assign fe_raw    = (clk_s == 2'b10);
    assign fe_armed  = fe_raw && armed;
    assign tmo_hit   = !fe_raw && (cnt == TMO_LAST);
    assign rx_ack    = rx_valid && (rx_byte == 8'hFA);
    assign rx_nak    = rx_valid && (rx_byte == 8'hFE);
    assign resend_ok = RESEND_EN && (retry_cnt < RETRY_W'(MAX_RETRY));
    assign dbg_state = state;

    always_comb begin
        fail      = 1'b0;
        fail_code = 2'b00;
        case (state)
            SEND: begin
                if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            LACK: begin
                if (fe_armed && dat_s[1]) begin
                    fail      = 1'b1;
                    fail_code = ERR_NO_ACK;
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            WAIT_RESP: begin
                if (rx_nak && !resend_ok) begin
                    fail      = 1'b1;
                    fail_code = ERR_NAK;
                end else if (tmo_hit && !rx_ack && !rx_nak) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            clk_s        <= 2'b11;
            dat_s        <= 2'b11;
            cmd_q        <= 8'h00;
            parity_q     <= 1'b0;
            cnt          <= '0;
            bit_idx      <= 4'd0;
            armed        <= 1'b0;
            retry_cnt    <= '0;
            ps2_clk_drv  <= 1'b0;
            ps2_data_drv <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            rx_hold      <= 1'b0;
            resp_ok      <= 1'b0;
            resp_err     <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            clk_s    <= {clk_s[0], ps2_clk_in};
            dat_s    <= {dat_s[0], ps2_data_in};
            resp_ok  <= 1'b0;
            resp_err <= 1'b0;
            err_code <= 2'b00;

            if (fail) begin
                resp_err     <= 1'b1;
                err_code     <= fail_code;
                ps2_clk_drv  <= 1'b0;
                ps2_data_drv <= 1'b0;
                cmd_ready    <= 1'b1;
                busy         <= 1'b0;
                rx_hold      <= 1'b0;
                state        <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid && cmd_ready) begin
                            cmd_q        <= cmd_data;
                            parity_q     <= ~^cmd_data;
                            retry_cnt    <= '0;
                            cnt          <= '0;
                            ps2_clk_drv  <= 1'b1;
                            ps2_data_drv <= (INHIBIT_CYCLES == 1);
                            cmd_ready    <= 1'b0;
                            busy         <= 1'b1;
                            rx_hold      <= 1'b1;
                            state        <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == INH_LAST) begin
                            ps2_clk_drv <= 1'b0;
                            state       <= RTS;
                        end else begin
                            // Start bit goes onto the line during the last inhibit cycle.
                            if (cnt == INH_PRE) begin
                                ps2_data_drv <= 1'b1;
                            end
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RTS: begin
                        bit_idx <= 4'd0;
                        armed   <= 1'b0;
                        cnt     <= '0;
                        state   <= SEND;
                    end
                    SEND: begin
                        // Arm only once the released clock is seen high, so the
                        // host's own inhibit release can never count as a device edge.
                        if (!armed && clk_s[1]) begin
                            armed <= 1'b1;
                        end
                        cnt <= fe_raw ? '0 : cnt + 1'b1;
                        if (fe_armed) begin
                            case (bit_idx)
                                4'd8:    ps2_data_drv <= ~parity_q;
                                4'd9:    ps2_data_drv <= 1'b0;
                                default: ps2_data_drv <= ~cmd_q[bit_idx[2:0]];
                            endcase
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'd9) begin
                                state <= LACK;
                            end
                        end
                    end
                    LACK: begin
                        cnt <= fe_raw ? '0 : cnt + 1'b1;
                        if (fe_armed) begin
                            rx_hold <= 1'b0;
                            cnt     <= '0;
                            state   <= WAIT_RESP;
                        end
                    end
                    WAIT_RESP: begin
                        cnt <= fe_raw ? '0 : cnt + 1'b1;
                        if (rx_ack) begin
                            resp_ok   <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else if (rx_nak) begin
                            // Only reached when another resend is allowed.
                            retry_cnt    <= retry_cnt + 1'b1;
                            cnt          <= '0;
                            ps2_clk_drv  <= 1'b1;
                            ps2_data_drv <= (INHIBIT_CYCLES == 1);
                            rx_hold      <= 1'b1;
                            state        <= INHIBIT;
                        end
                    end
                    default: begin
                        ps2_clk_drv  <= 1'b0;
                        ps2_data_drv <= 1'b0;
                        cmd_ready    <= 1'b1;
                        busy         <= 1'b0;
                        rx_hold      <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: open-drain device model on the PS/2 lines, response scoreboard,
// directed command vectors. Build with PS2_RESEND_EN defined to exercise the resend path.
module tb_ps2_host_ctrl;
    localparam int INH  = 40;
    localparam int TMO  = 500;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;

    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_drv;
    logic       ps2_data_drv;
    logic       cmd_ready;
    logic       rx_hold;
    logic       busy;
    logic       resp_ok;
    logic       resp_err;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    localparam logic [3:0] EXP_OK    = 4'b1000;
    localparam logic [3:0] EXP_TMO   = 4'b0101;
    localparam logic [3:0] EXP_NOACK = 4'b0110;
    localparam logic [3:0] EXP_NAK   = 4'b0111;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_drv;
    assign ps2_data_in = dev_data & ~ps2_data_drv;

    ps2_host_ctrl #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_drv(ps2_clk_drv),
        .ps2_data_drv(ps2_data_drv),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .rx_hold(rx_hold),
        .busy(busy),
        .resp_ok(resp_ok),
        .resp_err(resp_err),
        .err_code(err_code),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every resp pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (resp_ok || resp_err) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got ok=%0b err=%0b code=%0b with nothing expected",
                         resp_ok, resp_err, err_code);
            end else begin
                check("resp", {resp_ok, resp_err, err_code}, exp_q.pop_front());
            end
            if (resp_err) begin
                check("drv_released_on_err", {ps2_clk_drv, ps2_data_drv}, 2'b00);
            end
        end
    end

    task automatic issue_cmd(input logic [7:0] b);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_ready_after_accept", cmd_ready, 0);
        check("busy_after_accept", busy, 1);
    endtask

    // Device side of a host-to-device frame: measures the inhibit, clocks 11 edges,
    // samples what the host puts on the data line and optionally ACKs.
    task automatic dev_run(input logic [7:0] b, input logic par, input bit give_ack);
        int k;
        int inh;
        logic [9:0] bits;
        bits = '0;
        k = 0;
        while (!ps2_clk_drv && k < 50) begin
            k++;
            @(negedge clk);
        end
        inh = 0;
        while (ps2_clk_drv && inh < 20 * INH) begin
            inh++;
            @(negedge clk);
        end
        check("inhibit_len", inh, INH);
        check("start_bit", ps2_data_in, 0);
        repeat (4) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && give_ack) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (e <= 10) bits[e-1] = ps2_data_in;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        check("data_bits", bits[7:0], b);
        check("parity_bit", bits[8], par);
        check("stop_bit", bits[9], 1);
    endtask

    task automatic dev_respond(input logic [7:0] b);
        repeat (3) @(negedge clk);
        check("rx_hold_in_wait", rx_hold, 0);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            k++;
            @(negedge clk);
        end
        check("idle_reached", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int el;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_drv", {ps2_clk_drv, ps2_data_drv}, 2'b00);
        check("rst_rx_hold", rx_hold, 0);
        check("rst_resp", {resp_ok, resp_err, err_code}, 4'b0000);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED: six ones, so the odd-parity bit is 1; a non-response byte is ignored first
        exp_q.push_back(EXP_OK);
        issue_cmd(8'hED);
        fork
            dev_run(8'hED, 1'b1, 1'b1);
            begin
                repeat (2) @(negedge clk);
                cmd_valid = 1'b1;
                cmd_data  = 8'h00;
                repeat (10) @(negedge clk);
                check("busy_ignores_cmd", cmd_ready, 0);
                check("rx_hold_in_inhibit", rx_hold, 1);
                cmd_valid = 1'b0;
            end
        join
        dev_respond(8'hAA);
        check("other_byte_ignored", busy, 1);
        dev_respond(8'hFA);
        wait_idle(50);

        // 0xFF with a silent device: timeout while waiting for clock edges
        exp_q.push_back(EXP_TMO);
        issue_cmd(8'hFF);
        k = 0;
        while (ps2_clk_drv && k < 20 * INH) begin
            k++;
            @(negedge clk);
        end
        el = 0;
        while (!resp_err && el < 3 * TMO) begin
            el++;
            @(negedge clk);
        end
        check("timeout_latency_in_range", (el >= TMO && el <= TMO + 2), 1);
        wait_idle(50);

        // 0xF4 (five ones, parity 0): device leaves data high at the ACK edge
        exp_q.push_back(EXP_NOACK);
        issue_cmd(8'hF4);
        dev_run(8'hF4, 1'b0, 1'b0);
        wait_idle(50);

`ifdef PS2_RESEND_EN
        // 0xF3 (six ones, parity 1): two NAKs then ACK -> three inhibit phases
        exp_q.push_back(EXP_OK);
        issue_cmd(8'hF3);
        for (int r = 0; r < 3; r++) begin
            dev_run(8'hF3, 1'b1, 1'b1);
            dev_respond((r < 2) ? 8'hFE : 8'hFA);
        end
        wait_idle(50);

        // Four NAKs: three resends, then NAK error
        exp_q.push_back(EXP_NAK);
        issue_cmd(8'hF3);
        for (int r = 0; r < 4; r++) begin
            dev_run(8'hF3, 1'b1, 1'b1);
            dev_respond(8'hFE);
        end
        wait_idle(50);
`else
        // 0xF3 answered by NAK: immediate error without resend
        exp_q.push_back(EXP_NAK);
        issue_cmd(8'hF3);
        dev_run(8'hF3, 1'b1, 1'b1);
        dev_respond(8'hFE);
        check("no_reinhibit_after_nak", ps2_clk_drv, 0);
        wait_idle(50);
`endif

        // 0x0F: reset while bit 4 (a 0, so data is pulled low) is on the line
        issue_cmd(8'h0F);
        k = 0;
        while (ps2_clk_drv && k < 20 * INH) begin
            k++;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        for (int e = 1; e <= 5; e++) begin
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (e < 5) begin
                repeat (HALF) @(negedge clk);
                dev_clk = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
        check("bit4_driven_low", ps2_data_drv, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_drv", {ps2_clk_drv, ps2_data_drv}, 2'b00);
        @(negedge clk);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);
        check("idle_after_rst", busy, 0);

        // Recovery: a normal transfer after the reset
        exp_q.push_back(EXP_OK);
        issue_cmd(8'hED);
        dev_run(8'hED, 1'b1, 1'b1);
        dev_respond(8'hFA);
        wait_idle(50);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
